// File: rtl/button_debounce_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_pkg
// Shared types and constants for the pushbutton conditioning block.
//   btn_state_t              : debouncer FSM states
//   CLK_HZ                   : system clock frequency the defaults are derived from
//   DEFAULT_DEBOUNCE_CYCLES  : 10 ms stable time at CLK_HZ
//   DEFAULT_LONG_CYCLES      : 1 s hold time at CLK_HZ
// -----------------------------------------------------------------------------
package button_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    localparam int CLK_HZ                  = 100_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int DEFAULT_LONG_CYCLES     = CLK_HZ;

endpackage

// File: rtl/button_debounce_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-stage flip-flop synchroniser for one asynchronous input bit.
//   clk  in  1  system clock
//   rst  in  1  synchronous active-high reset, loads RST_VAL into every stage
//   d    in  1  asynchronous input
//   q    out 1  synchronised output (STAGES clk edges of latency)
// -----------------------------------------------------------------------------
module sync_ff
    import button_debounce_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Reset loads the idle level so the debouncer does not see a phantom edge
    // coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Conditions one raw pushbutton pin into a clean level plus single-cycle
// press / release / long-press events.
//   clk            in  1  system clock
//   rst            in  1  synchronous active-high reset
//   btn_in         in  1  raw asynchronous pin
//   btn_level      out 1  debounced pressed level (1 = pressed)
//   press          out 1  one-cycle pulse on accepted press
//   release_pulse  out 1  one-cycle pulse on accepted release
//   long_press     out 1  one-cycle pulse when the hold reaches LONG_CYCLES
//   held_long      out 1  long press reached; cleared on accepted release
// -----------------------------------------------------------------------------
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic held_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(LONG_CYCLES) + 1;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
    localparam logic RAW_RELEASED = ACTIVE_LOW;

    btn_state_t    state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic          level_n, held_n, press_n, release_n, long_n;
    logic          hold_count;
    logic          sync_raw;
    logic          s;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RAW_RELEASED)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (sync_raw)
    );

    // Polarity is corrected after the synchroniser so s is always 1 = pressed.
    assign s = sync_raw ^ ACTIVE_LOW;

    // Next-state logic. A change is accepted only after s has held the new
    // value through a full debounce window; any disagreement aborts the
    // window, including on the terminal cycle. The hold counter keeps running
    // in RELEASE_WAIT so a long press can still be reported while a release
    // is being qualified.
    always_comb begin
        state_n    = state;
        dcnt_n     = dcnt;
        hcnt_n     = hcnt;
        level_n    = btn_level;
        held_n     = held_long;
        press_n    = 1'b0;
        release_n  = 1'b0;
        long_n     = 1'b0;
        hold_count = 1'b0;

        case (state)
            IDLE: begin
                if (s) begin
                    state_n = PRESS_WAIT;
                    dcnt_n  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_n = IDLE;
                end else if (dcnt == D_LAST) begin
                    state_n = HELD;
                    press_n = 1'b1;
                    level_n = 1'b1;
                    hcnt_n  = '0;
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            HELD: begin
                hold_count = 1'b1;
                if (!s) begin
                    state_n = RELEASE_WAIT;
                    dcnt_n  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_n    = HELD;
                    hold_count = 1'b1;
                end else if (dcnt == D_LAST) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                    level_n   = 1'b0;
                    held_n    = 1'b0;
                    hcnt_n    = '0;
                end else begin
                    dcnt_n     = dcnt + 1'b1;
                    hold_count = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // The hold counter parks at its terminal value; held_long keeps the
        // pulse from repeating until the release clears both.
        if (hold_count) begin
            if (hcnt == H_LAST) begin
                if (!held_long) begin
                    long_n = 1'b1;
                    held_n = 1'b1;
                end
            end else begin
                hcnt_n = hcnt + 1'b1;
            end
        end
    end

    // State, counters and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dcnt          <= '0;
            hcnt          <= '0;
            btn_level     <= 1'b0;
            held_long     <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state         <= state_n;
            dcnt          <= dcnt_n;
            hcnt          <= hcnt_n;
            btn_level     <= level_n;
            held_long     <= held_n;
            press         <= press_n;
            release_pulse <= release_n;
            long_press    <= long_n;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
// Drives two button_debounce instances (active-high pin and active-low pin)
// with directed waveforms. A run-length model of the debounce rules predicts
// every output each cycle; a few literal latency/count checks pin the model.
// -----------------------------------------------------------------------------
module tb_button_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LNG  = 20;

    logic clk = 1'b0;
    logic rst;
    logic btn_a, btn_b;
    logic lvl_a, prs_a, rel_a, lng_a, hld_a;
    logic lvl_b, prs_b, rel_b, lng_b, hld_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit modelValid = 1'b0;

    // model state, index 0 = active-high pin, 1 = active-low pin
    logic pipe [2][SYNC];
    int   run   [2];
    bit   mLvl  [2];
    int   since [2];
    bit   fired [2];
    bit   ePress[2];
    bit   eRel  [2];
    bit   eLong [2];

    // observed event bookkeeping
    int pressCnt[2], relCnt[2], longCnt[2];
    int pressCyc[2], relCyc[2], longCyc[2];

    button_debounce #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_a),
        .btn_level(lvl_a), .press(prs_a), .release_pulse(rel_a),
        .long_press(lng_a), .held_long(hld_a)
    );

    button_debounce #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_b),
        .btn_level(lvl_b), .press(prs_b), .release_pulse(rel_b),
        .long_press(lng_b), .held_long(hld_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d",
                     name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic b, input int n);
        btn_a = a;
        btn_b = b;
        repeat (n) @(negedge clk);
    endtask

    // Model rule: the debounced level flips once the synchronised sample has
    // disagreed with it for DEB+1 consecutive edges; a long press is due LNG
    // edges after the press while still pressed, once per press.
    task automatic modelStep(input int k, input logic raw);
        bit   s;
        logic idleRaw;
        idleRaw  = (k == 1);
        ePress[k] = 1'b0;
        eRel[k]   = 1'b0;
        eLong[k]  = 1'b0;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) pipe[k][i] = idleRaw;
            run[k]   = 0;
            mLvl[k]  = 1'b0;
            since[k] = 0;
            fired[k] = 1'b0;
            return;
        end
        s = pipe[k][0] ^ idleRaw;
        for (int i = 0; i < SYNC - 1; i++) pipe[k][i] = pipe[k][i+1];
        pipe[k][SYNC-1] = raw;
        if (s != mLvl[k]) run[k]++;
        else run[k] = 0;
        if (run[k] == DEB + 1) begin
            run[k]  = 0;
            mLvl[k] = !mLvl[k];
            since[k] = 0;
            if (mLvl[k]) ePress[k] = 1'b1;
            else begin
                eRel[k]  = 1'b1;
                fired[k] = 1'b0;
            end
        end else if (mLvl[k]) begin
            since[k]++;
            if (since[k] == LNG && !fired[k]) begin
                eLong[k] = 1'b1;
                fired[k] = 1'b1;
            end
        end
    endtask

    // Model advances on the same edge the DUT registers its outputs.
    always @(posedge clk) begin
        cyc++;
        modelStep(0, btn_a);
        modelStep(1, btn_b);
        if (rst) modelValid = 1'b1;
    end

    // Compare every cycle once a reset has been seen, and log events.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("level_a", lvl_a, mLvl[0]);
            checkOutput("press_a", prs_a, ePress[0]);
            checkOutput("release_a", rel_a, eRel[0]);
            checkOutput("long_a", lng_a, eLong[0]);
            checkOutput("held_a", hld_a, fired[0]);
            checkOutput("level_b", lvl_b, mLvl[1]);
            checkOutput("press_b", prs_b, ePress[1]);
            checkOutput("release_b", rel_b, eRel[1]);
            checkOutput("long_b", lng_b, eLong[1]);
            checkOutput("held_b", hld_b, fired[1]);
            if (prs_a === 1'b1) begin pressCnt[0]++; pressCyc[0] = cyc; end
            if (rel_a === 1'b1) begin relCnt[0]++;   relCyc[0]   = cyc; end
            if (lng_a === 1'b1) begin longCnt[0]++;  longCyc[0]  = cyc; end
            if (prs_b === 1'b1) begin pressCnt[1]++; pressCyc[1] = cyc; end
            if (rel_b === 1'b1) begin relCnt[1]++;   relCyc[1]   = cyc; end
            if (lng_b === 1'b1) begin longCnt[1]++;  longCyc[1]  = cyc; end
        end
    end

    initial begin
        int t0;
        int snap;
        for (int k = 0; k < 2; k++) begin
            pressCnt[k] = 0; relCnt[k] = 0; longCnt[k] = 0;
            pressCyc[k] = -1000; relCyc[k] = -1000; longCyc[k] = -1000;
            run[k] = 0; mLvl[k] = 0; since[k] = 0; fired[k] = 0;
            ePress[k] = 0; eRel[k] = 0; eLong[k] = 0;
            for (int i = 0; i < SYNC; i++) pipe[k][i] = 1'b0;
        end

        // reset with both pins at their released level
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("rst_level", lvl_a, 0);
        checkOutput("rst_press", prs_a, 0);
        checkOutput("rst_held", hld_a, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 2);

        // clean press: pulse exactly 7 edges after the rise
        t0 = cyc;
        applyStimulus(1'b1, 1'b1, 12);
        checkOutput("press_latency", pressCyc[0] - t0, 7);
        checkOutput("press_count", pressCnt[0], 1);
        checkOutput("level_after_press", lvl_a, 1);

        // keep holding: one long press 20 cycles after press
        applyStimulus(1'b1, 1'b1, 25);
        checkOutput("long_offset", longCyc[0] - pressCyc[0], 20);
        checkOutput("held_long_set", hld_a, 1);

        // short low glitch while held is ignored
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b1, 1'b1, 10);
        checkOutput("glitch_no_release", relCnt[0], 0);
        checkOutput("glitch_level", lvl_a, 1);
        checkOutput("long_count", longCnt[0], 1);

        // clean release
        t0 = cyc;
        applyStimulus(1'b0, 1'b1, 12);
        checkOutput("release_latency", relCyc[0] - t0, 7);
        checkOutput("held_long_clear", hld_a, 0);
        checkOutput("level_after_release", lvl_a, 0);

        // 3-cycle bounce is rejected
        snap = pressCnt[0];
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 12);
        checkOutput("bounce_no_press", pressCnt[0] - snap, 0);
        checkOutput("bounce_level", lvl_a, 0);

        // active-low pin: held high never pressed; drop to 0 presses at +7
        checkOutput("al_idle_no_press", pressCnt[1], 0);
        t0 = cyc;
        applyStimulus(1'b0, 1'b0, 12);
        checkOutput("al_press_latency", pressCyc[1] - t0, 7);
        checkOutput("al_level", lvl_b, 1);
        applyStimulus(1'b0, 1'b1, 12);

        // reset while held with held_long set: outputs clear, no release
        applyStimulus(1'b1, 1'b1, 32);
        checkOutput("pre_rst_held_long", hld_a, 1);
        snap = relCnt[0];
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("rst_mid_level", lvl_a, 0);
        checkOutput("rst_mid_held", hld_a, 0);
        checkOutput("rst_mid_release", rel_a, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 15);
        checkOutput("rst_no_release", relCnt[0] - snap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
